mem_access_unit: RTL

//  Sequential successor to the combinational mem read/write controllers. Accepts one load/store per

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the MEM stage and mem_access_unit.
// The MEM stage is the master and the unit is the slave.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: region decode, byte-lane steering, word-crossing split
// into two accesses, and sign/zero-extended load results with a single-cycle response pulse.
module mem_access_unit #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned ADDR_W           = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wmask,
  output logic                dmem_en,
  output logic                dmem_we,
  output logic                imem_we,
  output logic                bios_en,
  input  logic [31:0]         dmem_rdata,
  input  logic [31:0]         bios_rdata
);

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam logic [3:0] REG_DMEM = 4'b0001;
  localparam logic [3:0] REG_IMEM = 4'b0010;
  localparam logic [3:0] REG_MIX  = 4'b0011;
  localparam logic [3:0] REG_BIOS = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP, S_FAULT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic              split_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word0_q;
  logic [31:0]       word1_q;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Request decode, evaluated on the incoming request while IDLE.
  logic [3:0]  in_region;
  logic [1:0]  in_off;
  logic [2:0]  in_size;
  logic        in_bad_f3;
  logic        in_region_ok;
  logic        in_split;
  logic        in_misal;
  logic        in_cross;
  logic        in_fault;
  logic [31:0] in_wdata;

  always_comb begin
    in_region = bus.req_addr[ADDR_W-1 -: 4];
    in_off    = bus.req_addr[1:0];
    in_size   = size_of(bus.req_funct3);
    if (bus.req_is_store) begin
      in_bad_f3    = bus.req_funct3[2] | (&bus.req_funct3[1:0]);
      in_region_ok = (in_region == REG_DMEM) || (in_region == REG_MIX) ||
                     (in_region == REG_IMEM);
    end else begin
      in_bad_f3    = (&bus.req_funct3[1:0]) | (bus.req_funct3[2] & bus.req_funct3[1]);
      in_region_ok = (in_region == REG_DMEM) || (in_region == REG_MIX) ||
                     (in_region == REG_BIOS);
    end
    in_split = ({2'b00, in_off} + {1'b0, in_size}) > 4'd4;
    in_misal = ((in_size == 3'd2) && in_off[0]) || ((in_size == 3'd4) && (in_off != 2'd0));
    // The next word lands in another region exactly when the word-index bits below
    // the region field are all ones, so no full-width increment is needed here.
    in_cross = in_split && (&bus.req_addr[ADDR_W-5:2]);
    in_fault = in_bad_f3 || !in_region_ok || (in_misal && !ALLOW_MISALIGNED) || in_cross;
    case (in_size)
      3'd1:    in_wdata = {24'h0, bus.req_wdata[7:0]};
      3'd2:    in_wdata = {16'h0, bus.req_wdata[15:0]};
      default: in_wdata = bus.req_wdata;
    endcase
  end

  // Lane steering for the latched request.
  logic [1:0]  off_q;
  logic [3:0]  region_q;
  logic [2:0]  size_q;
  logic        bios_q;
  logic [4:0]  sh;
  logic [3:0]  smask;
  logic [31:0] d_lo, d_hi, r32, ld_res, rd_word;
  logic [3:0]  m_lo, m_hi;

  assign rd_word = bios_q ? bios_rdata : dmem_rdata;

  always_comb begin
    off_q    = addr_q[1:0];
    region_q = addr_q[ADDR_W-1 -: 4];
    size_q   = size_of(f3_q);
    bios_q   = (region_q == REG_BIOS);
    sh       = {off_q, 3'b000};
    case (size_q)
      3'd1:    smask = 4'b0001;
      3'd2:    smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
    d_lo = wdata_q << sh;
    d_hi = wdata_q >> (6'd32 - {1'b0, sh});
    m_lo = smask << off_q;
    m_hi = smask >> (3'd4 - {1'b0, off_q});
    r32  = (word0_q >> sh) | (word1_q << (6'd32 - {1'b0, sh}));
    case (f3_q)
      FNC_LB:  ld_res = {{24{r32[7]}}, r32[7:0]};
      FNC_LH:  ld_res = {{16{r32[15]}}, r32[15:0]};
      FNC_LW:  ld_res = r32;
      FNC_LBU: ld_res = {24'h0, r32[7:0]};
      FNC_LHU: ld_res = {16'h0, r32[15:0]};
      default: ld_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      split_q <= 1'b0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        f3_q    <= bus.req_funct3;
        store_q <= bus.req_is_store;
        split_q <= in_split;
        wdata_q <= in_wdata;
        word0_q <= '0;
        word1_q <= '0;
      end
      if (state == S_ACC1) word0_q <= rd_word;
      if (state == S_WAIT) begin
        if (split_q) word1_q <= rd_word;
        else         word0_q <= rd_word;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_fault = 1'b0;
    bus.resp_rdata = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    dmem_en        = 1'b0;
    dmem_we        = 1'b0;
    imem_we        = 1'b0;
    bios_en        = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = in_fault ? S_FAULT : S_ACC0;
      end
      S_ACC0, S_ACC1: begin
        mem_addr = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, (state == S_ACC1)};
        if (store_q) begin
          dmem_we   = (region_q == REG_DMEM) || (region_q == REG_MIX);
          imem_we   = (region_q == REG_IMEM) || (region_q == REG_MIX);
          mem_wmask = (state == S_ACC1) ? m_hi : m_lo;
          mem_wdata = (state == S_ACC1) ? d_hi : d_lo;
        end else begin
          dmem_en = !bios_q;
          bios_en = bios_q;
        end
        if (state == S_ACC0) state_nx = split_q ? S_ACC1 : S_WAIT;
        else                 state_nx = S_WAIT;
      end
      S_WAIT: state_nx = S_RESP;
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = store_q ? '0 : ld_res;
        state_nx       = S_IDLE;
      end
      S_FAULT: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = 1'b1;
        state_nx       = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
